// File: rtl/sample_window_avg_if.sv
// rtl/sample_window_avg_if.sv - valid/ready sample stream into the window averager
interface sample_window_avg_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/sample_window_avg.sv
// rtl/sample_window_avg.sv - signed 2**LOG2_N-sample window averager publishing a polled PIO word
// Optional per-window peak magnitude tracker: SAMPLE_WINDOW_AVG_PEAK_EN
module sample_window_avg #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 3,
  parameter int SEQ_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  sample_window_avg_if.slave smp,
  input  logic               clear,
  output logic [31:0]        out_word,
  output logic [31:0]        peak_word
);
  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  typedef enum logic {S_ACC, S_PUB} state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [LOG2_N-1:0]       cnt;
  logic [SEQ_W-1:0]        seq;
  logic                    valid_q;
  logic [15:0]             avg_q;
  logic                    ready_q;

  logic                     accept;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [DATA_W-1:0] avg_n;
  logic signed [15:0]       avg_16;

  assign smp.sample_ready = ready_q;
  assign accept           = smp.sample_valid && ready_q;
  assign sample_ext       = ACC_W'($signed(smp.sample_data));
  // Dropping the low LOG2_N bits is acc >>> LOG2_N; the quotient always fits DATA_W bits.
  assign avg_n            = acc[ACC_W-1:LOG2_N];
  assign avg_16           = 16'(avg_n);

  // Assemble the polled word; bits between valid and seq stay zero.
  always_comb begin
    out_word                 = '0;
    out_word[15:0]           = avg_q;
    out_word[16]             = valid_q;
    out_word[31 -: SEQ_W]    = seq;
  end

  // Accumulate / publish state machine; ready is registered so it is low during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_ACC;
      acc     <= '0;
      cnt     <= '0;
      seq     <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      ready_q <= 1'b0;
    end else if (clear) begin
      state   <= S_ACC;
      acc     <= '0;
      cnt     <= '0;
      seq     <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        S_ACC: begin
          ready_q <= 1'b1;
          if (accept) begin
            acc <= acc + sample_ext;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state   <= S_PUB;
              ready_q <= 1'b0;
            end
          end
        end
        S_PUB: begin
          avg_q   <= avg_16;
          seq     <= seq + 1'b1;
          valid_q <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
          ready_q <= 1'b1;
          state   <= S_ACC;
        end
        default: begin
          state   <= S_ACC;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef SAMPLE_WINDOW_AVG_PEAK_EN
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] peak_trk;
  logic [DATA_W-1:0] peak_q;

  // Unsigned magnitude; the most negative sample maps to 2**(DATA_W-1) without overflow.
  assign mag = smp.sample_data[DATA_W-1] ? ((~smp.sample_data) + DATA_W'(1)) : smp.sample_data;

  // Track the window maximum and hand it to peak_word on the publish cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_trk <= '0;
      peak_q   <= '0;
    end else if (clear) begin
      peak_trk <= '0;
      peak_q   <= '0;
    end else if (state == S_PUB) begin
      peak_q   <= peak_trk;
      peak_trk <= '0;
    end else if (accept && (mag > peak_trk)) begin
      peak_trk <= mag;
    end
  end

  assign peak_word = 32'(peak_q);
`else
  assign peak_word = 32'h0;
`endif
endmodule

// File: tb/tb_sample_window_avg.sv
// tb/tb_sample_window_avg.sv - scoreboard bench for sample_window_avg with a window-level reference model
module tb_sample_window_avg;
  localparam int DATA_W = 16;
  localparam int LOG2_N = 3;
  localparam int SEQ_W  = 8;
  localparam int N      = 1 << LOG2_N;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] out_word;
  logic [31:0] peak_word;

  sample_window_avg_if #(.DATA_W(DATA_W)) smp_if ();

  sample_window_avg #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .SEQ_W(SEQ_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .smp       (smp_if),
    .clear     (clear),
    .out_word  (out_word),
    .peak_word (peak_word)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [31:0] word;
    logic [31:0] peak;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cur_word  = 32'h0;
  logic [31:0] cur_peak  = 32'h0;
  logic [31:0] prev_word = 32'h0;

  int          win[$];
  int          m_seq = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_word = 32'h0;
  logic [31:0] pend_peak = 32'h0;
  bit          exp_rdy = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference: floor of the window mean, sequence modulo 2**SEQ_W, peak = max |sample|.
  function automatic logic [31:0] model_pub();
    int sum = 0;
    int pk  = 0;
    int q;
    int a;
    foreach (win[i]) begin
      sum += win[i];
      a = (win[i] < 0) ? -win[i] : win[i];
      if (a > pk) pk = a;
    end
    q = sum / N;
    if ((sum % N != 0) && (sum < 0)) q = q - 1;
    m_seq = (m_seq + 1) % (1 << SEQ_W);
`ifdef SAMPLE_WINDOW_AVG_PEAK_EN
    pend_peak = 32'(pk);
`else
    pend_peak = 32'h0;
`endif
    return (32'(m_seq) << (32 - SEQ_W)) | 32'h0001_0000 | (32'(q) & 32'h0000_FFFF);
  endfunction

  // One clock of stimulus; the model decides what the DUT must show after the coming edge.
  task automatic step(input bit v, input logic [15:0] d, input bit c);
    int e;
    @(negedge clk);
    smp_if.sample_valid = v;
    smp_if.sample_data  = d;
    clear               = c;
    chk("sample_ready", {31'b0, smp_if.sample_ready}, {31'b0, exp_rdy});
    e = cyc + 1;
    if (c) begin
      win.delete();
      m_seq = 0;
      pend  = 1'b0;
      exp_q.push_back('{e, 32'h0, 32'h0});
      exp_rdy = 1'b1;
    end else if (pend) begin
      exp_q.push_back('{e, pend_word, pend_peak});
      pend    = 1'b0;
      exp_rdy = 1'b1;
    end else begin
      exp_rdy = 1'b1;
      if (v) begin
        win.push_back(int'($signed(d)));
        if (win.size() == N) begin
          pend_word = model_pub();
          win.delete();
          pend    = 1'b1;
          exp_rdy = 1'b0;
        end
      end
    end
    @(posedge clk);
  endtask

  // Monitor: pops expectations as their edge passes and checks whenever the output or expectation moves.
  bit   upd;
  exp_t it;
  always @(negedge clk) begin
    upd = 1'b0;
    if (reset_n) begin
      while (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
        it       = exp_q.pop_front();
        cur_word = it.word;
        cur_peak = it.peak;
        upd      = 1'b1;
      end
      if (upd || (out_word !== prev_word)) begin
        chk("out_word", out_word, cur_word);
        chk("peak_word", peak_word, cur_peak);
      end
      prev_word = out_word;
    end
  end

  bit          rv;
  bit          rc;
  bit          last_v;
  logic [15:0] rd;
  logic [15:0] last_d;

  initial begin
    smp_if.sample_valid = 1'b0;
    smp_if.sample_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_word", out_word, 32'h0);
    chk("reset_peak_word", peak_word, 32'h0);
    chk("reset_ready", {31'b0, smp_if.sample_ready}, 32'h0);
    reset_n = 1'b1;
    exp_rdy = 1'b1;

    // 8 x 100 back to back
    repeat (N) step(1'b1, 16'd100, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    #1 chk("t1_word", out_word, 32'h0101_0064);

    // -3/-4 alternating, next window starts right after the publish cycle
    for (int i = 0; i < N; i++) step(1'b1, (i % 2 == 0) ? 16'hFFFD : 16'hFFFC, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    #1 chk("t2_word", out_word, 32'h0201_FFFC);

    // full-scale extremes
    repeat (N) step(1'b1, 16'h7FFF, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    #1 chk("t3_max_word", out_word, 32'h0301_7FFF);
    repeat (N) step(1'b1, 16'h8000, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    #1 chk("t3_min_word", out_word, 32'h0401_8000);
`ifdef SAMPLE_WINDOW_AVG_PEAK_EN
    chk("t3_min_peak", peak_word, 32'h0000_8000);
`endif

    // 256 windows of zero: sequence wraps back to 4
    for (int w = 0; w < 256; w++) begin
      repeat (N) step(1'b1, 16'd0, 1'b0);
      step(1'b0, 16'd0, 1'b0);
    end
    #1 chk("t4_wrap_word", out_word, 32'h0401_0000);

    // partial window then clear (sample during clear discarded), clear held with valid
    repeat (5) step(1'b1, 16'd50, 1'b0);
    step(1'b1, 16'd77, 1'b1);
    #1 chk("t5_clear_word", out_word, 32'h0);
    repeat (3) step(1'b1, 16'd5, 1'b1);
    repeat (N) step(1'b1, 16'd10, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    #1 chk("t5_word", out_word, 32'h0101_000A);

    // clear on the publish cycle suppresses that publish
    repeat (N) step(1'b1, 16'd20, 1'b0);
    step(1'b1, 16'd9, 1'b1);
    #1 chk("clear_in_pub", out_word, 32'h0);

    // peak window
    step(1'b1, 16'd5, 1'b0);
    step(1'b1, 16'hFED4, 1'b0);
    step(1'b1, 16'd7, 1'b0);
    repeat (N - 3) step(1'b1, 16'd0, 1'b0);
    step(1'b0, 16'd0, 1'b0);
`ifdef SAMPLE_WINDOW_AVG_PEAK_EN
    #1 chk("t6_peak", peak_word, 32'h0000_012C);
`else
    #1 chk("t6_peak_tied", peak_word, 32'h0);
`endif

    // asynchronous reset mid-window: outputs drop at once, partial sum lost
    repeat (3) step(1'b1, 16'd1000, 1'b0);
    @(negedge clk);
    smp_if.sample_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_word", out_word, 32'h0);
    chk("async_rst_peak", peak_word, 32'h0);
    chk("async_rst_ready", {31'b0, smp_if.sample_ready}, 32'h0);
    win.delete();
    exp_q.delete();
    m_seq    = 0;
    pend     = 1'b0;
    cur_word = 32'h0;
    cur_peak = 32'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_rdy = 1'b1;
    repeat (N) step(1'b1, 16'd8, 1'b0);
    step(1'b0, 16'd0, 1'b0);
    #1 chk("post_rst_word", out_word, 32'h0101_0008);

    // randomized traffic with occasional clears; data/valid held while ready is low
    last_v = 1'b0;
    last_d = '0;
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rd = 16'($urandom);
      rc = ($urandom_range(0, 63) == 0);
      if (!exp_rdy && last_v) begin
        rv = last_v;
        rd = last_d;
      end
      step(rv, rd, rc);
      last_v = rv;
      last_d = rd;
    end
    repeat (3) step(1'b0, 16'd0, 1'b0);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
